car_move_ctrl: RTL and testbench
================================

CAR_MOVE_CTRL -- requirements
Module: car_move_ctrl

Interface
REQ-001 SHALL expose parameter N_CARS, default 8, number of cars in the table (car 0 is the target car).
REQ-002 SHALL expose parameter GRID, default 6, board width and height in cells.
REQ-003 SHALL expose parameter TMO_CYC, default 16, collision-check timeout in cycles.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 load_valid  input  1  write one table entry.
REQ-007 load_idx / load_x / load_y / load_orient / load_len  input  3/3/3/1/2  entry to write (orient 1 = horizontal; len 2 or 3).
REQ-008 move_valid  input  1  move request.
REQ-009 move_ready  output  1  request can be accepted this cycle.
REQ-010 move_idx / move_dir  input  3/1  car to move; direction 1 = +1 cell, 0 = -1 cell along its orientation.
REQ-011 chk_valid  output  1  candidate position is presented to the collision detector.
REQ-012 carX / carY / carOrient / carIndex  output  3/3/1/3  candidate position, orientation and index of the moving car.
REQ-013 carLen  output  2  candidate car length.
REQ-014 chk_done / collision  input  1/1  detector verdict; collision is valid only when chk_done=1.
REQ-015 move_done / move_ok  output  1/1  one-cycle completion pulse and its result.
REQ-016 win  output  1  car 0 occupies the exit: x + len == GRID.
REQ-017 rd_idx  input  3  combinational display read address.
REQ-018 rd_x / rd_y / rd_orient / rd_len  output  3/3/1/2  combinational display read data.

Function
REQ-019 SHALL implement an FSM with states IDLE, BOUNDS, CHECK and DONE.
REQ-020 move_ready SHALL equal (state==IDLE && !load_valid); load takes priority over a move in the same cycle.
REQ-021 load_valid SHALL write the entry only in IDLE and SHALL be ignored in all other states.
REQ-022 A move SHALL be accepted on the edge where move_valid && move_ready; the index and direction are latched and the FSM goes to BOUNDS.
REQ-023 BOUNDS: if dir=0 and the coordinate equals 0, or dir=1 and coordinate + len == GRID, the FSM SHALL go to DONE with ok=0 and without asserting chk_valid.
REQ-024 Otherwise BOUNDS SHALL go to CHECK; the candidate is the coordinate ±1 along the orientation, with the other axis unchanged.
REQ-025 CHECK SHALL hold chk_valid=1 and the candidate outputs stable until chk_done=1 is sampled.
REQ-026 chk_done=1 with collision=0 SHALL commit the candidate to the table and go to DONE with ok=1.
REQ-027 chk_done=1 with collision=1 SHALL go to DONE with ok=0 and leave the table unchanged.
REQ-028 DONE SHALL assert move_done=1 for exactly one cycle with move_ok valid, then return to IDLE.
REQ-029 Minimum latency: move_done SHALL rise 2 cycles after acceptance for a bounds reject, and 3 cycles for a move whose chk_done arrives in the first CHECK cycle.
REQ-030 All arithmetic SHALL be unsigned 3-bit; because of REQ-023 no wrap-around can occur.
REQ-031 win SHALL be combinational from the entry of car 0.
REQ-032 Outside CHECK, chk_valid SHALL be 0 and carX, carY, carOrient, carIndex and carLen SHALL be 0.

Reset
REQ-033 While rst_n=0: state IDLE, chk_valid=0, move_done=0, move_ok=0, and all candidate outputs 0.
REQ-034 While rst_n=0 the table SHALL load the default layout from the package; an in-flight move is abandoned and no move_done is issued.

Configuration
REQ-035 Macro CAR_MOVE_TIMEOUT_EN is defined: in CHECK, if chk_done is not sampled within TMO_CYC cycles, the FSM SHALL go to DONE with ok=0 and drop chk_valid.
REQ-036 Macro CAR_MOVE_TIMEOUT_EN is not defined: CHECK SHALL wait indefinitely and no timeout counter is present.

Structure
REQ-037 Package car_pkg SHALL hold GRID, N_CARS, the state enum, the car-entry struct (x, y, orient, len) and the default layout constant.
REQ-038 Sub-module car_table SHALL hold the register file: one synchronous write port and two combinational read ports (the move port and rd_idx).

Verification
REQ-039 Reset, then read car 0 -> default layout entry on rd_*; move_ready=1; win=0.
REQ-040 Load car 1 at (2,3), horizontal, len 2; move car 1 dir=1; chk_done=1, collision=0 in the first CHECK cycle -> carX=3, carY=3, carIndex=1; move_done 3 cycles after accept with ok=1; rd reads x=3.
REQ-041 Car 1 at (4,3), horizontal, len 2, dir=1 -> no chk_valid; move_done 2 cycles after accept with ok=0.
REQ-042 Collision=1 returned on the fifth CHECK cycle -> ok=0, table unchanged, candidate outputs held stable through all five cycles.
REQ-043 load_valid and move_valid in the same IDLE cycle -> load written, move_ready=0, move accepted the next cycle; with the macro defined, chk_done held 0 -> ok=0 after TMO_CYC cycles.
REQ-044 Car 0 at (3,2), horizontal, len 2, dir=1 accepted -> win=1 after commit; rst_n pulsed low mid-CHECK -> state IDLE, no move_done.

Source files
------------

// File: rtl/car_pkg.sv
// Shared types and constants for the car move controller.
package car_pkg;

    localparam int GRID   = 6;
    localparam int N_CARS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNDS = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // orient 1 = horizontal (moves along x), 0 = vertical (moves along y)
    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       orient;
        logic [1:0] len;
    } car_t;

    // Layout loaded while in reset; car 0 is the target car.
    localparam car_t DEFAULT_LAYOUT [N_CARS] = '{
        '{3'd0, 3'd2, 1'b1, 2'd2},
        '{3'd0, 3'd0, 1'b0, 2'd3},
        '{3'd1, 3'd0, 1'b1, 2'd2},
        '{3'd5, 3'd0, 1'b0, 2'd3},
        '{3'd2, 3'd4, 1'b1, 2'd3},
        '{3'd3, 3'd1, 1'b0, 2'd2},
        '{3'd4, 3'd3, 1'b0, 2'd2},
        '{3'd0, 3'd5, 1'b1, 2'd2}
    };

    // Entries beyond the default layout start empty.
    function automatic car_t default_car(input int i);
        if (i >= 0 && i < N_CARS) begin
            return DEFAULT_LAYOUT[i];
        end
        return '0;
    endfunction

endpackage

// File: rtl/car_move_ctrl_if.sv
// Move request handshake and collision-detector bus.
interface car_move_ctrl_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] move_idx;
    logic       move_dir;
    logic       chk_valid;
    logic [2:0] carX;
    logic [2:0] carY;
    logic       carOrient;
    logic [2:0] carIndex;
    logic [1:0] carLen;
    logic       chk_done;
    logic       collision;
    logic       move_done;
    logic       move_ok;

    modport master (
        output move_valid, move_idx, move_dir, chk_done, collision,
        input  move_ready, chk_valid, carX, carY, carOrient, carIndex, carLen,
               move_done, move_ok
    );

    modport slave (
        input  move_valid, move_idx, move_dir, chk_done, collision,
        output move_ready, chk_valid, carX, carY, carOrient, carIndex, carLen,
               move_done, move_ok
    );
endinterface

// File: rtl/car_move_ctrl_table.sv
// Car register file: one synchronous write port, two combinational read
// ports, plus car 0 broken out for the win detector.
module car_table
    import car_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  car_t       wdata,
    input  logic [2:0] ra_idx,
    output car_t       ra_data,
    input  logic [2:0] rb_idx,
    output car_t       rb_data,
    output car_t       car0
);

    car_t tab_q [N];
    car_t tab_d [N];

    // Next table contents: single-entry write
    always_comb begin
        tab_d = tab_q;
        if (we) begin
            tab_d[waddr] = wdata;
        end
    end

    // Table storage, default layout while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                tab_q[i] <= default_car(i);
            end
        end else begin
            tab_q <= tab_d;
        end
    end

    assign ra_data = tab_q[ra_idx];
    assign rb_data = tab_q[rb_idx];
    assign car0    = tab_q[0];

endmodule

// File: rtl/car_move_ctrl.sv
// Car move controller: accepts single-cell moves, rejects moves off the
// board, asks an external detector about collisions and commits the result.
// Optional macro CAR_MOVE_TIMEOUT_EN adds a CHECK-state timeout.
//
// state  | meaning
// IDLE   | accept table loads or a move request
// BOUNDS | reject a move that would leave the board
// CHECK  | present candidate to the detector, wait for chk_done
// DONE   | one-cycle move_done pulse with move_ok
module car_move_ctrl
    import car_pkg::*;
#(
    parameter int N_CARS  = 8,
    parameter int GRID    = 6,
    parameter int TMO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    input  logic [2:0]      load_idx,
    input  logic [2:0]      load_x,
    input  logic [2:0]      load_y,
    input  logic            load_orient,
    input  logic [1:0]      load_len,
    car_move_ctrl_if.slave  mif,
    output logic            win,
    input  logic [2:0]      rd_idx,
    output logic [2:0]      rd_x,
    output logic [2:0]      rd_y,
    output logic            rd_orient,
    output logic [1:0]      rd_len
);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       dir_q, dir_d;
    logic       ok_q, ok_d;

    logic       tbl_we;
    logic [2:0] tbl_waddr;
    car_t       tbl_wdata;
    car_t       mv_ent, rd_ent, car0_ent, cand;
    logic [2:0] coord, coord_n;
    logic       at_edge;

`ifdef CAR_MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    car_table #(.N(N_CARS)) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_we),
        .waddr   (tbl_waddr),
        .wdata   (tbl_wdata),
        .ra_idx  (idx_q),
        .ra_data (mv_ent),
        .rb_idx  (rd_idx),
        .rb_data (rd_ent),
        .car0    (car0_ent)
    );

    // Candidate position of the latched car; table is frozen outside IDLE
    // so this stays stable for the whole CHECK state.
    always_comb begin
        coord   = mv_ent.orient ? mv_ent.x : mv_ent.y;
        at_edge = dir_q ? (({1'b0, coord} + {2'b00, mv_ent.len}) == 4'(GRID))
                        : (coord == 3'd0);
        coord_n = dir_q ? (coord + 3'd1) : (coord - 3'd1);
        cand    = mv_ent;
        if (mv_ent.orient) begin
            cand.x = coord_n;
        end else begin
            cand.y = coord_n;
        end
    end

    // Next-state, table write and output decode
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        dir_d          = dir_q;
        ok_d           = ok_q;
        tbl_we         = 1'b0;
        tbl_waddr      = load_idx;
        tbl_wdata      = '{load_x, load_y, load_orient, load_len};
        mif.move_ready = 1'b0;
        mif.chk_valid  = 1'b0;
        mif.carX       = 3'd0;
        mif.carY       = 3'd0;
        mif.carOrient  = 1'b0;
        mif.carIndex   = 3'd0;
        mif.carLen     = 2'd0;
        mif.move_done  = 1'b0;
        mif.move_ok    = 1'b0;
`ifdef CAR_MOVE_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mif.move_ready = !load_valid;
                if (load_valid) begin
                    tbl_we = 1'b1;
                end else if (mif.move_valid) begin
                    idx_d   = mif.move_idx;
                    dir_d   = mif.move_dir;
                    state_d = ST_BOUNDS;
                end
            end
            ST_BOUNDS: begin
                if (at_edge) begin
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
`ifdef CAR_MOVE_TIMEOUT_EN
                    tmo_d   = TW'(TMO_CYC - 1);
`endif
                end
            end
            ST_CHECK: begin
                mif.chk_valid = 1'b1;
                mif.carX      = cand.x;
                mif.carY      = cand.y;
                mif.carOrient = cand.orient;
                mif.carIndex  = idx_q;
                mif.carLen    = cand.len;
                if (mif.chk_done) begin
                    if (!mif.collision) begin
                        tbl_we    = 1'b1;
                        tbl_waddr = idx_q;
                        tbl_wdata = cand;
                        ok_d      = 1'b1;
                    end else begin
                        ok_d      = 1'b0;
                    end
                    state_d = ST_DONE;
                end
`ifdef CAR_MOVE_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tmo_d   = tmo_q - 1'b1;
                end
`endif
            end
            ST_DONE: begin
                mif.move_done = 1'b1;
                mif.move_ok   = ok_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and move context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            dir_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            ok_q    <= ok_d;
        end
    end

`ifdef CAR_MOVE_TIMEOUT_EN
    // CHECK-state timeout down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign win       = (({1'b0, car0_ent.x} + {2'b00, car0_ent.len}) == 4'(GRID));
    assign rd_x      = rd_ent.x;
    assign rd_y      = rd_ent.y;
    assign rd_orient = rd_ent.orient;
    assign rd_len    = rd_ent.len;

endmodule

// File: tb/tb_car_move_ctrl.sv
// Scoreboard bench for car_move_ctrl.
module tb_car_move_ctrl;

    localparam int GRID_W  = 6;
    localparam int TMO     = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [2:0] load_idx = '0, load_x = '0, load_y = '0;
    logic       load_orient = 1'b0;
    logic [1:0] load_len = '0;
    logic       win;
    logic [2:0] rd_idx = '0;
    logic [2:0] rd_x, rd_y;
    logic       rd_orient;
    logic [1:0] rd_len;

    car_move_ctrl_if mif ();

    always #5 clk = ~clk;

    car_move_ctrl #(.N_CARS(8), .GRID(GRID_W), .TMO_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_idx    (load_idx),
        .load_x      (load_x),
        .load_y      (load_y),
        .load_orient (load_orient),
        .load_len    (load_len),
        .mif         (mif),
        .win         (win),
        .rd_idx      (rd_idx),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_orient   (rd_orient),
        .rd_len      (rd_len)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference board
    int mx[8], my[8], mo[8], ml[8];

    task automatic model_reset();
        mx = '{0, 0, 1, 5, 2, 3, 4, 0};
        my = '{2, 0, 0, 0, 4, 1, 3, 5};
        mo = '{1, 0, 1, 0, 1, 0, 0, 1};
        ml = '{2, 3, 2, 3, 3, 2, 2, 2};
    endtask

    typedef struct {
        int ok; int lat; int nchk; int idx; int cx; int cy; int co; int cl;
    } exp_t;
    exp_t sb[$];

    task automatic set_load(input int i, input int x, input int y, input int o, input int l);
        load_idx = 3'(i); load_x = 3'(x); load_y = 3'(y);
        load_orient = 1'(o); load_len = 2'(l);
    endtask

    task automatic model_load();
        mx[load_idx] = int'(load_x); my[load_idx] = int'(load_y);
        mo[load_idx] = int'(load_orient); ml[load_idx] = int'(load_len);
    endtask

    task automatic load_car(input int i, input int x, input int y, input int o, input int l);
        @(negedge clk);
        set_load(i, x, y, o, l);
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        model_load();
    endtask

    // resp = CHECK cycle on which chk_done is returned; 0 = never
    task automatic predict(input int i, input int dir, input int resp, input int coll);
        exp_t e;
        int c;
        c = mo[i] ? mx[i] : my[i];
        e.idx = i; e.co = mo[i]; e.cl = ml[i];
        e.cx = mx[i]; e.cy = my[i];
        if ((dir == 0 && c == 0) || (dir == 1 && c + ml[i] == GRID_W)) begin
            e.ok = 0; e.lat = 2; e.nchk = 0;
        end else begin
            if (mo[i] != 0) e.cx = dir ? mx[i] + 1 : mx[i] - 1;
            else            e.cy = dir ? my[i] + 1 : my[i] - 1;
            if (resp == 0) begin
                e.ok = 0; e.lat = 2 + TMO; e.nchk = TMO;
            end else begin
                e.ok = (coll == 0) ? 1 : 0; e.lat = 2 + resp; e.nchk = resp;
            end
        end
        sb.push_back(e);
    endtask

    task automatic run_move(input int i, input int dir, input int resp, input int coll,
                            input bit clash);
        int lat, nchk;
        bit done;
        exp_t e;
        @(negedge clk);
        mif.move_idx = 3'(i); mif.move_dir = 1'(dir); mif.move_valid = 1'b1;
        if (clash) begin
            load_valid = 1'b1;
            #1 check("ready_during_load", int'(mif.move_ready), 0);
            @(posedge clk);
            #1 load_valid = 1'b0;
            model_load();
            @(negedge clk);
        end
        predict(i, dir, resp, coll);
        check("move_ready", int'(mif.move_ready), 1);
        @(posedge clk);
        #1 mif.move_valid = 1'b0;
        lat = 1; nchk = 0; done = 0;
        for (int k = 0; k < 200; k++) begin
            if (mif.chk_valid) begin
                nchk++;
                check("cand_x", int'(mif.carX), sb[0].cx);
                check("cand_y", int'(mif.carY), sb[0].cy);
                check("cand_idx", int'(mif.carIndex), sb[0].idx);
                check("cand_orient", int'(mif.carOrient), sb[0].co);
                check("cand_len", int'(mif.carLen), sb[0].cl);
                mif.chk_done  = (resp != 0 && nchk == resp);
                mif.collision = 1'(coll);
            end else begin
                mif.chk_done = 1'b0; mif.collision = 1'b0;
            end
            if (mif.move_done) begin
                e = sb.pop_front();
                check("move_ok", int'(mif.move_ok), e.ok);
                check("latency", lat, e.lat);
                check("chk_cycles", nchk, e.nchk);
                if (e.ok != 0) begin
                    mx[i] = e.cx; my[i] = e.cy;
                end
                done = 1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
        if (!done) begin
            check("move_done_seen", 0, 1);
            void'(sb.pop_front());
        end
        mif.chk_done = 1'b0; mif.collision = 1'b0;
        @(posedge clk);
        #1 check("move_done_pulse", int'(mif.move_done), 0);
    endtask

    task automatic check_entry(input string tag, input int i);
        rd_idx = 3'(i);
        #1;
        check({tag, "_x"}, int'(rd_x), mx[i]);
        check({tag, "_y"}, int'(rd_y), my[i]);
        check({tag, "_o"}, int'(rd_orient), mo[i]);
        check({tag, "_l"}, int'(rd_len), ml[i]);
    endtask

    initial begin
        bit seen;
        mif.move_valid = 1'b0; mif.move_idx = '0; mif.move_dir = 1'b0;
        mif.chk_done = 1'b0; mif.collision = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_chk_valid", int'(mif.chk_valid), 0);
        check("rst_move_done", int'(mif.move_done), 0);
        check("rst_move_ok", int'(mif.move_ok), 0);
        check("rst_carX", int'(mif.carX), 0);
        @(negedge clk) rst_n = 1'b1;
        rd_idx = 3'd0;
        #1;
        check("rst_car0_x", int'(rd_x), 0);
        check("rst_car0_y", int'(rd_y), 2);
        check("rst_car0_o", int'(rd_orient), 1);
        check("rst_car0_l", int'(rd_len), 2);
        check("rst_ready", int'(mif.move_ready), 1);
        check("rst_win", int'(win), 0);

        // car 0 at x=0 moving left: bounds reject
        run_move(0, 0, 1, 0, 0);
        check_entry("left_edge", 0);

        // commit in first CHECK cycle
        load_car(1, 2, 3, 1, 2);
        run_move(1, 1, 1, 0, 0);
        check_entry("commit", 1);

        // right edge reject
        load_car(1, 4, 3, 1, 2);
        run_move(1, 1, 1, 0, 0);
        check_entry("right_edge", 1);

        // collision on fifth CHECK cycle, vertical car
        load_car(2, 1, 1, 0, 3);
        run_move(2, 0, 5, 1, 0);
        check_entry("collide", 2);

        // load and move in the same cycle
        set_load(3, 5, 1, 0, 2);
`ifdef CAR_MOVE_TIMEOUT_EN
        run_move(3, 1, 0, 0, 1);
`else
        run_move(3, 1, 3, 0, 1);
`endif
        check_entry("clash", 3);

        // target car reaches exit
        load_car(0, 3, 2, 1, 2);
        check("win_before", int'(win), 0);
        run_move(0, 1, 1, 0, 0);
        check("win_after", int'(win), 1);

        // reset in the middle of CHECK
        @(negedge clk);
        mif.move_idx = 3'd2; mif.move_dir = 1'b1; mif.move_valid = 1'b1;
        @(posedge clk);
        #1 mif.move_valid = 1'b0;
        @(posedge clk);
        #1 check("mid_chk_valid", int'(mif.chk_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_chk_valid", int'(mif.chk_valid), 0);
        check("rst_mid_move_done", int'(mif.move_done), 0);
        check("rst_mid_carY", int'(mif.carY), 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 if (mif.move_done) seen = 1;
        end
        check("no_done_after_rst", int'(seen), 0);
        check("ready_after_rst", int'(mif.move_ready), 1);
        check_entry("default_after_rst", 0);
        check("win_after_rst", int'(win), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
